avalon_pixel_reader: RTL and testbench
======================================

AVALON_PIXEL_READER -- requirements
Module: avalon_pixel_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4 (power of two, 2..16), which sets the return-data FIFO depth and the read-credit limit.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle job-start pulse.
REQ-005 SHALL have port startpixel, input, 32, first word byte address (inclusive).
REQ-006 SHALL have port endpixel, input, 32, last word byte address (inclusive).
REQ-007 SHALL have port address, output, 32, Avalon-MM master read address.
REQ-008 SHALL have port read, output, 1, Avalon-MM read request.
REQ-009 SHALL have port waitrequest, input, 1, slave stall.
REQ-010 SHALL have port readdata, input, 32, returned word.
REQ-011 SHALL have port readdatavalid, input, 1, return strobe (pipelined reads).
REQ-012 SHALL have port pix_data, output, 32, FIFO head word.
REQ-013 SHALL have port pix_valid, output, 1, FIFO non-empty.
REQ-014 SHALL have port pix_ready, input, 1, downstream accept.
REQ-015 SHALL have port busy, output, 1, high while the state is not IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle job-complete pulse.
REQ-017 SHALL have port err, output, 1, one-cycle bad-range pulse (see Configuration).

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-019 SHALL, in IDLE on start=1, latch cur_addr=startpixel and last=endpixel, then go to ISSUE.
REQ-020 SHALL ignore start in every state other than IDLE.
REQ-021 SHALL assert read no earlier than the first cycle in ISSUE, and only when outstanding+fifo_count < FIFO_DEPTH.
REQ-022 SHALL, once read is asserted, hold read and address stable until the cycle with read=1 and waitrequest=0 (accept).
REQ-023 SHALL, on accept, increment outstanding and set cur_addr=cur_addr+4 (modulo 2^32).
REQ-024 SHALL go to DRAIN and deassert read on the cycle after an accept where the accepted address equals last.
REQ-025 SHALL, on readdatavalid=1, push readdata into the FIFO and decrement outstanding.
REQ-026 SHALL discard readdatavalid when outstanding=0 (no push, no underflow).
REQ-027 SHALL never overflow the FIFO; credit accounting guarantees room for every outstanding return.
REQ-028 SHALL drive pix_valid=(fifo_count!=0) and pix_data=FIFO head; a pop occurs on pix_valid and pix_ready.
REQ-029 SHALL leave fifo_count unchanged on a simultaneous push and pop; a full FIFO with a pop still accepts a push.
REQ-030 SHALL sustain one accept per cycle when waitrequest=0 and pix_ready=1 continuously.
REQ-031 SHALL, in DRAIN, go to DONE when outstanding=0 and fifo_count=0.
REQ-032 SHALL, in DONE, drive done=1 for exactly one cycle, then return to IDLE.
REQ-033 SHALL make a new start possible on the cycle after done.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, force state IDLE, read=0, address=0, busy=0, done=0, err=0, pix_valid=0, outstanding=0, and flush the FIFO.
REQ-035 SHALL, on reset mid-job, abort the job; returns arriving after reset are discarded per REQ-026.

Configuration
REQ-036 SHALL, with macro PIXEL_READER_RANGE_CHECK_EN defined, on start with endpixel<startpixel or either low two bits nonzero, issue no reads, pulse err for one cycle, and stay in IDLE.
REQ-037 SHALL, without PIXEL_READER_RANGE_CHECK_EN, tie err=0, force the low two bits of both addresses to 0, and treat endpixel<startpixel as an empty job (IDLE->DONE, done pulse, no reads).

Verification
REQ-038 SHALL cover: start, 0x100..0x10C, waitrequest=0, 2-cycle read latency, pix_ready=1 -> 4 accepts at 0x100/104/108/10C, 4 words out in order, done one cycle after the last pop.
REQ-039 SHALL cover: waitrequest=1 for 3 cycles on the first request -> read and address=0x100 stable for 4 cycles; one accept only.
REQ-040 SHALL cover: pix_ready=0, 10-word job, FIFO_DEPTH=4 -> accepts stop at 4 with read=0; after pix_ready=1, all 10 words delivered and done pulses.
REQ-041 SHALL cover: rst=1 with 2 reads outstanding, then 2 stray readdatavalid -> busy=0, pix_valid=0, no FIFO push.
REQ-042 SHALL cover: start with startpixel=0x20 and endpixel=0x10 -> with macro, err pulse and no read; without macro, done pulse and no read.

Source files
------------

// File: rtl/avalon_pixel_reader.sv
// avalon_pixel_reader: Avalon-MM pipelined read master streaming a word range into a FIFO.
// Optional PIXEL_READER_RANGE_CHECK_EN rejects reversed or misaligned ranges with err.
module avalon_pixel_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] startpixel,
    input  logic [31:0] endpixel,
    output logic [31:0] address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [31:0] mem [FIFO_DEPTH];
    logic [31:0] last, sp, ep;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] outstanding, count, out_n, cnt_n;
    logic acc, push, pop, bad, empty, read_n;
`ifdef PIXEL_READER_RANGE_CHECK_EN
    assign sp = startpixel;
    assign ep = endpixel;
    assign bad = (endpixel < startpixel) || (startpixel[1:0] != 2'b00) || (endpixel[1:0] != 2'b00);
    assign empty = 1'b0;
`else
    assign sp = startpixel & ~32'h3;
    assign ep = endpixel & ~32'h3;
    assign bad = 1'b0;
    assign empty = ep < sp;
`endif
    assign acc = read && !waitrequest;
    assign push = readdatavalid && outstanding != '0;
    assign pop = pix_valid && pix_ready;
    assign pix_valid = count != '0;
    assign pix_data = mem[rd_ptr];
    assign out_n = outstanding + CW'(acc) - CW'(push);
    assign cnt_n = count + CW'(push) - CW'(pop);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start && !bad) state_n = empty ? DONE : ISSUE;
            ISSUE: if (acc && address == last) state_n = DRAIN;
            DRAIN: if (out_n == '0 && cnt_n == '0) state_n = DONE;
            DONE:  state_n = IDLE;
        endcase
        // a stalled request is held; a new one needs a free FIFO slot for its return
        read_n = state_n == ISSUE && ((read && waitrequest) ||
                 ({1'b0, out_n} + {1'b0, cnt_n} < (CW+1)'(FIFO_DEPTH)));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            read <= 1'b0;
            address <= '0;
            last <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            outstanding <= '0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_n;
            read <= read_n;
            busy <= state_n != IDLE;
            done <= state_n == DONE;
            err <= state == IDLE && start && bad;
            outstanding <= out_n;
            count <= cnt_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (state == IDLE && start && !bad) begin
                address <= sp;
                last <= ep;
            end else if (acc) begin
                address <= address + 32'd4;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= readdata;
    end
endmodule

// File: tb/tb_avalon_pixel_reader.sv
// tb_avalon_pixel_reader: directed and randomized jobs against a transaction-level model
// with a pipelined Avalon slave; honours PIXEL_READER_RANGE_CHECK_EN like the design.
module tb_avalon_pixel_reader;
    localparam int DEPTH = 4;
    logic clk = 0, rst = 1, start = 0, waitrequest = 0, readdatavalid = 0, pix_ready = 0;
    logic read, pix_valid, busy, done, err;
    logic [31:0] startpixel = 0, endpixel = 0, readdata = 0, address, pix_data;
    int passed = 0, total = 0;
    always #5 clk = ~clk;
    avalon_pixel_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .startpixel(startpixel), .endpixel(endpixel),
        .address(address), .read(read), .waitrequest(waitrequest), .readdata(readdata),
        .readdatavalid(readdatavalid), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .done(done), .err(err)
    );
    typedef struct { int due; logic [31:0] data; } ret_t;
    ret_t rq[$];
    logic [31:0] exp_addr[$], exp_data[$];
    int cyc = 0, lat = 2, stall_left = 0, ready_mode = 1;
    bit rand_wr = 0;
    int out_m = 0, fifo_m = 0, acc_cnt = 0, pop_cnt = 0, done_cnt = 0, err_cnt = 0, pre_acc_reads = 0;
    int first_acc_cyc = 0, last_acc_cyc = 0, last_pop_cyc = 0, done_cyc = 0, last_due = 0;
    int d0 = 0, err0 = 0, job_n = 0;
    bit job_bad = 0;
    logic prev_stall = 0, prev_done = 0;
    logic [31:0] prev_addr = 0;
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    // slave, consumer and transaction model, all evaluated mid-cycle
    initial forever begin
        @(negedge clk);
        cyc++;
        waitrequest = (stall_left > 0 && read) || (rand_wr && $urandom_range(0, 3) == 0);
        if (stall_left > 0 && read) stall_left--;
        pix_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        readdatavalid = rq.size() > 0 && rq[0].due <= cyc;
        readdata = readdatavalid ? rq[0].data : $urandom;
        if (readdatavalid) void'(rq.pop_front());
        if (rst) begin
            out_m = 0;
            fifo_m = 0;
            prev_stall = 0;
            prev_done = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_read", 32'(read), 1);
                chk("hold_addr", address, prev_addr);
            end
            if (read) chk("read_busy", 32'(busy), 1);
            chk("pix_valid", 32'(pix_valid), 32'(fifo_m != 0));
            chk("credit", 32'(out_m + fifo_m <= DEPTH), 1);
            if (done) begin
                chk("done_width", 32'(prev_done), 0);
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) err_cnt++;
            if (read && acc_cnt == 0) pre_acc_reads++;
            if (readdatavalid && out_m > 0) begin
                out_m--;
                fifo_m++;
            end
            if (read && !waitrequest) begin
                if (acc_cnt == 0) first_acc_cyc = cyc;
                acc_cnt++;
                last_acc_cyc = cyc;
                out_m++;
                if (exp_addr.size() > 0) chk("acc_addr", address, exp_addr.pop_front());
                else chk("acc_extra", address, ~address);
                last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                rq.push_back('{last_due, word(address)});
            end
            if (pix_valid && pix_ready) begin
                if (exp_data.size() > 0) chk("pix_data", pix_data, exp_data.pop_front());
                else chk("pop_extra", pix_data, ~pix_data);
                pop_cnt++;
                last_pop_cyc = cyc;
                fifo_m--;
            end
            prev_done = done;
        end
        prev_stall = !rst && read && waitrequest;
        prev_addr = address;
    end
    task automatic setup_job(input logic [31:0] s, input logic [31:0] e);
        logic [31:0] a, b;
`ifdef PIXEL_READER_RANGE_CHECK_EN
        a = s;
        b = e;
        job_bad = e < s || s[1:0] != 2'b00 || e[1:0] != 2'b00;
`else
        a = {s[31:2], 2'b00};
        b = {e[31:2], 2'b00};
        job_bad = 0;
`endif
        acc_cnt = 0;
        pop_cnt = 0;
        pre_acc_reads = 0;
        job_n = 0;
        exp_addr.delete();
        exp_data.delete();
        if (!job_bad && b >= a) forever begin
            exp_addr.push_back(a);
            exp_data.push_back(word(a));
            job_n++;
            if (a == b) break;
            a += 4;
        end
        d0 = done_cnt;
        err0 = err_cnt;
        startpixel = s;
        endpixel = e;
        start = 1;
        tick(1);
        start = 0;
    endtask
    task automatic end_job(input int budget);
        int n = 0;
        if (job_bad) begin
            tick(4);
            chk("err_pulse", err_cnt - err0, 1);
            chk("no_done", done_cnt - d0, 0);
        end else begin
            while (done_cnt == d0 && n < budget) begin
                tick(1);
                n++;
            end
            chk("done_once", done_cnt - d0, 1);
            chk("err_none", err_cnt - err0, 0);
        end
        chk("accepts", acc_cnt, job_n);
        chk("pops", pop_cnt, job_n);
        chk("busy_end", 32'(busy), 0);
    endtask
    initial begin
        int n;
        logic [31:0] s;
        tick(3);
        chk("rst_read", 32'(read), 0);
        chk("rst_addr", address, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        rst = 0;
        tick(2);
        setup_job(32'h100, 32'h10C);
        chk("busy_start", 32'(busy), 1);
        end_job(60);
        chk("back_to_back", last_acc_cyc - first_acc_cyc, 3);
        chk("done_after_pop", done_cyc - last_pop_cyc, 1);
        stall_left = 3;
        setup_job(32'h100, 32'h100);
        end_job(60);
        chk("stall_read_cycles", pre_acc_reads, 4);
        ready_mode = 0;
        setup_job(32'h200, 32'h224);
        tick(20);
        chk("credit_accepts", acc_cnt, 4);
        chk("credit_read_low", 32'(read), 0);
        chk("credit_pix_valid", 32'(pix_valid), 1);
        ready_mode = 1;
        end_job(100);
        lat = 4;
        ready_mode = 0;
        setup_job(32'h300, 32'h31C);
        n = 0;
        while (acc_cnt < 2 && n < 20) begin
            tick(1);
            n++;
        end
        chk("two_outstanding", 32'(acc_cnt >= 2), 1);
        rst = 1;
        exp_addr.delete();
        exp_data.delete();
        tick(1);
        rst = 0;
        tick(8);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pix_valid", 32'(pix_valid), 0);
        chk("abort_read", 32'(read), 0);
        chk("abort_no_done", done_cnt - d0, 0);
        lat = 2;
        ready_mode = 1;
        setup_job(32'h20, 32'h10);
        end_job(20);
        setup_job(32'h402, 32'h40D);
        end_job(60);
        setup_job(32'hFFFF_FFF8, 32'hFFFF_FFFC);
        end_job(60);
        rand_wr = 1;
        ready_mode = 2;
        for (int j = 0; j < 12; j++) begin
            lat = $urandom_range(1, 4);
            s = 32'h1000 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            setup_job(s, s + 32'(4 * $urandom_range(0, 11)));
            end_job(400);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
